// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state and command record shared by the ALU command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Opcode and operands of one command. The tag width is a parameter of the
  // sequencer, so the tag is concatenated above this record in the FIFO word.
  typedef struct packed {
    logic [1:0] sel;
    logic [1:0] x;
    logic [1:0] y;
  } cmd_t;

endpackage

// File: rtl/SimpleALU.sv
// SimpleALU: 2-bit combinational ALU (add, sub mod 16, mul, dot product of bit vectors).
// Latency: combinational.
// Backpressure: none; out is 0 whenever en is low.
// Ports: x, y operands; sel opcode; en enable; out 4-bit result.
module SimpleALU (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] out
);

  always_comb begin
    out = 4'd0;
    if (en) begin
      case (sel)
        2'b00:   out = {2'b00, x} + {2'b00, y};
        2'b01:   out = {2'b00, x} - {2'b00, y};
        2'b10:   out = {2'b00, x} * {2'b00, y};
        default: out = {3'b000, x[0] & y[0]} + {3'b000, x[1] & y[1]};
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO for sequencer commands.
// Latency: a pushed word is visible at the head one cycle after the push (no bypass).
// Backpressure: push is ignored when full, pop is ignored when empty; full/empty come from registered pointers.
// Ports: clk/rst; push/push_data write side; pop/pop_data read side (pop_data is the head);
//        full, empty and count (occupancy, 0..DEPTH) status.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The extra pointer bit tells a full FIFO (wrap bits differ) from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands, issues them one at a time, returns tagged results in order.
// Latency: command accepted at edge N -> res_valid after edge N+2 (empty FIFO, FSM idle); 2 cycles/result sustained.
// Backpressure: cmd_ready = !full; a stalled result holds the FSM in RESP and lets the FIFO fill.
// Ports: cmd_* command input (valid/ready), alu_* drive/receive the external ALU,
//        res_* tagged result output (valid/ready), busy = work pending anywhere.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_sel,
  input  logic [1:0]       cmd_x,
  input  logic [1:0]       cmd_y,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [1:0]       alu_x,
  output logic [1:0]       alu_y,
  output logic [1:0]       alu_sel,
  output logic             alu_en,
  input  logic [3:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic [1:0]       res_op,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  localparam int WORD_W = TAG_W + $bits(cmd_t);

  state_t                 state;
  cmd_t                   in_cmd;
  cmd_t                   head_cmd;
  logic [TAG_W-1:0]       head_tag;
  logic [TAG_W-1:0]       tag_q;
  logic [WORD_W-1:0]      fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count;

  assign in_cmd = '{sel: cmd_sel, x: cmd_x, y: cmd_y};
  assign {head_tag, head_cmd} = fifo_rd_data;

  // Pop exactly when the FSM loads the head: from IDLE, or straight out of
  // RESP on the result handshake so back-to-back commands skip IDLE.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) || ((state == RESP) && res_ready));

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data ({cmd_tag, in_cmd}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_sel   <= '0;
      alu_en    <= 1'b0;
      tag_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_tag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            alu_x   <= head_cmd.x;
            alu_y   <= head_cmd.y;
            alu_sel <= head_cmd.sel;
            tag_q   <= head_tag;
            alu_en  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Operands have been stable for the whole cycle; alu_sel is the opcode.
          res_data  <= alu_out;
          res_op    <= alu_sel;
          res_tag   <= tag_q;
          res_valid <= 1'b1;
          alu_en    <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!fifo_empty) begin
              alu_x   <= head_cmd.x;
              alu_y   <= head_cmd.y;
              alu_sel <= head_cmd.sel;
              tag_q   <= head_tag;
              alu_en  <= 1'b1;
              state   <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          alu_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for the sequencer with a SimpleALU in the loop.
// Latency: n/a.
// Backpressure: drives res_ready explicitly per scenario.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_sel;
  logic [1:0]       cmd_x;
  logic [1:0]       cmd_y;
  logic [TAG_W-1:0] cmd_tag;
  logic [1:0]       alu_x;
  logic [1:0]       alu_y;
  logic [1:0]       alu_sel;
  logic             alu_en;
  logic [3:0]       alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_data;
  logic [1:0]       res_op;
  logic [TAG_W-1:0] res_tag;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_tag(cmd_tag),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_en(alu_en), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_tag(res_tag), .busy(busy)
  );

  SimpleALU u_alu (.x(alu_x), .y(alu_y), .sel(alu_sel), .en(alu_en), .out(alu_out));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] sel, input logic [1:0] x, input logic [1:0] y,
                          input logic [TAG_W-1:0] tag);
    cmd_sel = sel; cmd_x = x; cmd_y = y; cmd_tag = tag; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        tick();
        cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    cmd_valid = 1'b0;
    total++; bad++;
    $display("FAIL push_timeout got=no_accept want=accept");
  endtask

  task automatic get_res(output logic [3:0] d, output logic [1:0] op, output logic [TAG_W-1:0] tag);
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        d = res_data; op = res_op; tag = res_tag;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        return;
      end
      tick();
    end
    d = 'x; op = 'x; tag = 'x;
    total++; bad++;
    $display("FAIL result_timeout got=no_result want=result");
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_sel = '0; cmd_x = '0; cmd_y = '0; cmd_tag = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b want=1", cmd_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", res_valid); end
    total++; if (res_data !== 4'd0 || res_op !== 2'd0 || res_tag !== 2'd0) begin
      bad++; $display("FAIL rst_res_fields got=%h/%h/%h want=0/0/0", res_data, res_op, res_tag); end
    total++; if (alu_x !== 2'd0 || alu_y !== 2'd0 || alu_sel !== 2'd0 || alu_en !== 1'b0) begin
      bad++; $display("FAIL rst_alu_ports got=%h/%h/%h/%b want=0/0/0/0", alu_x, alu_y, alu_sel, alu_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
  endtask

  task automatic test_single();
    push_cmd(OP_ADD, 2'd3, 2'd2, 2'd1);   // accepted at edge N
    total++; if (res_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_n got=valid%b busy%b want=valid0 busy1", res_valid, busy); end
    tick();                               // after N+1: ISSUE
    total++; if (alu_en !== 1'b1 || alu_x !== 2'd3 || alu_y !== 2'd2 || alu_sel !== OP_ADD || res_valid !== 1'b0) begin
      bad++; $display("FAIL single_issue got=en%b x%0d y%0d sel%0d v%b want=en1 x3 y2 sel0 v0",
                      alu_en, alu_x, alu_y, alu_sel, res_valid); end
    tick();                               // after N+2: result
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b want=1", res_valid); end
    total++; if (res_data !== 4'd5 || res_op !== OP_ADD || res_tag !== 2'd1) begin
      bad++; $display("FAIL single_result got=%h/%h/%h want=5/0/1", res_data, res_op, res_tag); end
    total++; if (alu_en !== 1'b0 || alu_out !== 4'd0) begin
      bad++; $display("FAIL single_resp_alu got=en%b out%h want=en0 out0", alu_en, alu_out); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_done got=valid%b busy%b want=0/0", res_valid, busy); end
  endtask

  task automatic test_ops();
    logic [3:0]       exp_d [3];
    logic [1:0]       exp_o [3];
    logic [TAG_W-1:0] exp_t [3];
    logic [3:0]       d;
    logic [1:0]       o;
    logic [TAG_W-1:0] t;
    exp_d = '{4'hF, 4'h2, 4'h9};
    exp_o = '{OP_SUB, OP_DOT, OP_MUL};
    exp_t = '{2'd2, 2'd3, 2'd0};
    push_cmd(OP_SUB, 2'd1, 2'd2, 2'd2);
    push_cmd(OP_DOT, 2'd3, 2'd3, 2'd3);
    push_cmd(OP_MUL, 2'd3, 2'd3, 2'd0);
    for (int i = 0; i < 3; i++) begin
      get_res(d, o, t);
      total++; if (d !== exp_d[i] || o !== exp_o[i] || t !== exp_t[i]) begin
        bad++; $display("FAIL ops_result%0d got=%h/%h/%h want=%h/%h/%h", i, d, o, t, exp_d[i], exp_o[i], exp_t[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] bx [6];
    logic [1:0] by [6];
    logic [3:0] got_d [5];
    logic [TAG_W-1:0] got_t [5];
    int got_c [5];
    int idx;
    int n;
    logic acc;
    bx = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    by = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    res_ready = 1'b0;
    idx = 0;
    cmd_valid = 1'b1; cmd_sel = OP_ADD; cmd_x = bx[0]; cmd_y = by[0]; cmd_tag = 2'd0;
    for (int c = 0; c < 12; c++) begin
      acc = cmd_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 6) begin cmd_x = bx[idx]; cmd_y = by[idx]; cmd_tag = idx[TAG_W-1:0]; end
      end
    end
    total++; if (idx !== 5) begin bad++; $display("FAIL bp_accepted got=%0d want=5", idx); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", cmd_ready); end
    total++; if (res_valid !== 1'b1 || res_data !== 4'd1) begin
      bad++; $display("FAIL bp_hold got=v%b d%h want=v1 d1", res_valid, res_data); end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 30 && n < 5; cyc++) begin
      if (cyc == 1) begin
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b want=1", cmd_ready); end
      end
      if (res_valid) begin got_d[n] = res_data; got_t[n] = res_tag; got_c[n] = cyc; n++; end
      tick();
    end
    res_ready = 1'b0;
    total++; if (n !== 5) begin bad++; $display("FAIL bp_count got=%0d want=5", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (got_d[i] !== 4'(i + 1) || got_t[i] !== 2'(i)) begin
        bad++; $display("FAIL bp_order%0d got=%h/%h want=%h/%h", i, got_d[i], got_t[i], 4'(i + 1), 2'(i)); end
      if (i > 0) begin
        total++; if (got_c[i] - got_c[i-1] !== 2) begin
          bad++; $display("FAIL bp_rate%0d got=%0d want=2", i, got_c[i] - got_c[i-1]); end
      end
    end
    tick();
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drained got=busy%b v%b want=0/0", busy, res_valid); end
  endtask

  task automatic test_push_pop();
    logic [3:0]       d;
    logic [1:0]       o;
    logic [TAG_W-1:0] t;
    logic [3:0]       exp_d [3];
    logic [1:0]       exp_o [3];
    logic [TAG_W-1:0] exp_t [3];
    int stray;
    exp_d = '{4'h6, 4'h5, 4'hF};
    exp_o = '{OP_MUL, OP_ADD, OP_SUB};
    exp_t = '{2'd2, 2'd3, 2'd0};
    res_ready = 1'b0;
    push_cmd(OP_SUB, 2'd3, 2'd1, 2'd1);
    push_cmd(OP_MUL, 2'd2, 2'd3, 2'd2);
    push_cmd(OP_ADD, 2'd2, 2'd3, 2'd3);
    total++; if (res_valid !== 1'b1 || res_data !== 4'd2 || res_tag !== 2'd1 || dut.u_fifo.count !== 3'd2) begin
      bad++; $display("FAIL pp_setup got=v%b d%h t%h cnt%0d want=v1 d2 t1 cnt2",
                      res_valid, res_data, res_tag, dut.u_fifo.count); end
    // Result handshake (pop) and a new push on the same edge.
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_sel = OP_SUB; cmd_x = 2'd0; cmd_y = 2'd1; cmd_tag = 2'd0;
    tick();
    res_ready = 1'b0; cmd_valid = 1'b0;
    total++; if (dut.u_fifo.count !== 3'd2) begin
      bad++; $display("FAIL pp_count got=%0d want=2", dut.u_fifo.count); end
    total++; if (res_valid !== 1'b0 || alu_en !== 1'b1 || alu_sel !== OP_MUL) begin
      bad++; $display("FAIL pp_issue got=v%b en%b sel%0d want=v0 en1 sel2", res_valid, alu_en, alu_sel); end
    for (int i = 0; i < 3; i++) begin
      get_res(d, o, t);
      total++; if (d !== exp_d[i] || o !== exp_o[i] || t !== exp_t[i]) begin
        bad++; $display("FAIL pp_result%0d got=%h/%h/%h want=%h/%h/%h", i, d, o, t, exp_d[i], exp_o[i], exp_t[i]); end
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid) stray++;
      tick();
    end
    total++; if (stray !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL pp_no_dup got=stray%0d busy%b want=0/0", stray, busy); end
  endtask

  task automatic test_reset_mid_resp();
    logic [3:0]       d;
    logic [1:0]       o;
    logic [TAG_W-1:0] t;
    int stray;
    res_ready = 1'b0;
    push_cmd(OP_ADD, 2'd1, 2'd1, 2'd0);
    push_cmd(OP_ADD, 2'd2, 2'd1, 2'd1);
    push_cmd(OP_ADD, 2'd2, 2'd2, 2'd2);
    push_cmd(OP_ADD, 2'd3, 2'd2, 2'd3);
    total++; if (res_valid !== 1'b1 || dut.u_fifo.count !== 3'd3) begin
      bad++; $display("FAIL mid_setup got=v%b cnt%0d want=v1 cnt3", res_valid, dut.u_fifo.count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_flush got=v%b busy%b rdy%b want=0/0/1", res_valid, busy, cmd_ready); end
    total++; if (res_data !== 4'd0 || alu_en !== 1'b0 || alu_x !== 2'd0) begin
      bad++; $display("FAIL mid_regs got=d%h en%b x%h want=0/0/0", res_data, alu_en, alu_x); end
    push_cmd(OP_MUL, 2'd1, 2'd3, 2'd2);
    get_res(d, o, t);
    total++; if (d !== 4'd3 || o !== OP_MUL || t !== 2'd2) begin
      bad++; $display("FAIL mid_next got=%h/%h/%h want=3/2/2", d, o, t); end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) stray++;
      tick();
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL mid_stray got=%0d want=0", stray); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_ops();
    test_backpressure();
    test_push_pop();
    test_reset_mid_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
